vmem_fb_ctrl: RTL

//  Double-buffered 1-bpp video framebuffer between the CPU store path and lcd_top; successor to the single 64-bit vmem_data bus.
//  CPU fills a back buffer word by word (one word = one display row of DATA_W pixels); LCD pixel requests read the front buffer.

---
 rtl/vmem_pkg.sv | 20 ++
 rtl/vmem_fb_ctrl_if.sv | 49 ++++
 rtl/vmem_fb_bank.sv | 49 ++++
 rtl/vmem_fb_ctrl.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/vmem_pkg.sv
// rtl/vmem_pkg.sv - shared types and constants for the vmem framebuffer controller
package vmem_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        CLEAR     = 2'd1,
        SWAP_WAIT = 2'd2
    } fb_state_e;

    localparam logic [23:0] FG_RGB_DEF = 24'hFFFFFF;
    localparam logic [23:0] BG_RGB_DEF = 24'h000000;
    localparam int          COORD_W    = 16;

    function automatic logic [23:0] bit_to_rgb(input logic b,
                                               input logic [23:0] fg,
                                               input logic [23:0] bg);
        return b ? fg : bg;
    endfunction

endpackage

// File: rtl/vmem_fb_ctrl_if.sv
// rtl/vmem_fb_ctrl_if.sv - CPU store path and LCD pixel bus of vmem_fb_ctrl (readback under VMEM_FB_READBACK_EN)
interface vmem_fb_ctrl_if #(
    parameter int DATA_W = 64,
    parameter int ROWS   = 64
);
    localparam int AW = $clog2(ROWS);

    logic                            cpu_wr_valid;
    logic                            cpu_wr_ready;
    logic [AW-1:0]                   cpu_wr_addr;
    logic [DATA_W-1:0]               cpu_wr_data;
    logic                            cpu_clr;
    logic                            cpu_swap;
    logic                            cpu_busy;
    logic                            lcd_vsync;
    logic                            lcd_req;
    logic [vmem_pkg::COORD_W-1:0]    lcd_x;
    logic [vmem_pkg::COORD_W-1:0]    lcd_y;
    logic                            lcd_pix_vld;
    logic [23:0]                     lcd_pix;
`ifdef VMEM_FB_READBACK_EN
    logic                            cpu_rd_en;
    logic [AW-1:0]                   cpu_rd_addr;
    logic [DATA_W-1:0]               cpu_rd_data;

    modport slave (
        input  cpu_wr_valid, cpu_wr_addr, cpu_wr_data, cpu_clr, cpu_swap,
        input  lcd_vsync, lcd_req, lcd_x, lcd_y, cpu_rd_en, cpu_rd_addr,
        output cpu_wr_ready, cpu_busy, lcd_pix_vld, lcd_pix, cpu_rd_data
    );
    modport master (
        output cpu_wr_valid, cpu_wr_addr, cpu_wr_data, cpu_clr, cpu_swap,
        output lcd_vsync, lcd_req, lcd_x, lcd_y, cpu_rd_en, cpu_rd_addr,
        input  cpu_wr_ready, cpu_busy, lcd_pix_vld, lcd_pix, cpu_rd_data
    );
`else
    modport slave (
        input  cpu_wr_valid, cpu_wr_addr, cpu_wr_data, cpu_clr, cpu_swap,
        input  lcd_vsync, lcd_req, lcd_x, lcd_y,
        output cpu_wr_ready, cpu_busy, lcd_pix_vld, lcd_pix
    );
    modport master (
        output cpu_wr_valid, cpu_wr_addr, cpu_wr_data, cpu_clr, cpu_swap,
        output lcd_vsync, lcd_req, lcd_x, lcd_y,
        input  cpu_wr_ready, cpu_busy, lcd_pix_vld, lcd_pix
    );
`endif

endinterface

// File: rtl/vmem_fb_bank.sv
// rtl/vmem_fb_bank.sv - ROWS x DATA_W bitmap bank, one write port, sync read port(s); second port under VMEM_FB_READBACK_EN
module vmem_fb_bank #(
    parameter int DATA_W = 64,
    parameter int ROWS   = 64,
    localparam int AW    = $clog2(ROWS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              rd0_en_i,
    input  logic [AW-1:0]     rd0_addr_i,
    output logic [DATA_W-1:0] rd0_data_o
`ifdef VMEM_FB_READBACK_EN
    ,
    input  logic              rd1_en_i,
    input  logic [AW-1:0]     rd1_addr_i,
    output logic [DATA_W-1:0] rd1_data_o
`endif
);

    logic [DATA_W-1:0] mem_q [ROWS];
    logic [DATA_W-1:0] rd0_q;

    // Storage has no reset so it maps onto plain RAM; only the read registers reset.
    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        rd0_q <= '0;
        else if (rd0_en_i) rd0_q <= mem_q[rd0_addr_i];
    end

    assign rd0_data_o = rd0_q;

`ifdef VMEM_FB_READBACK_EN
    logic [DATA_W-1:0] rd1_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        rd1_q <= '0;
        else if (rd1_en_i) rd1_q <= mem_q[rd1_addr_i];
    end

    assign rd1_data_o = rd1_q;
`endif

endmodule

// File: rtl/vmem_fb_ctrl.sv
// rtl/vmem_fb_ctrl.sv - double-buffered 1-bpp framebuffer with vsync swap and RGB expand; CPU readback under VMEM_FB_READBACK_EN
module vmem_fb_ctrl
    import vmem_pkg::*;
#(
    parameter int          DATA_W   = 64,
    parameter int          ROWS     = 64,
    parameter int          SCALE_SH = 2,
    parameter logic [23:0] FG_RGB   = FG_RGB_DEF,
    parameter logic [23:0] BG_RGB   = BG_RGB_DEF
) (
    input  logic          sys_clk,
    input  logic          sys_rst,
    vmem_fb_ctrl_if.slave bus
);

    localparam int AW = $clog2(ROWS);
    localparam int CW = $clog2(DATA_W);

    fb_state_e   state_q, state_d;
    logic        front_q, front_d;
    logic [AW-1:0] clr_cnt_q, clr_cnt_d;
    logic        swap_pend_q, swap_pend_d;
    logic        vsync_q;
    logic        vsync_rise;

    logic          pix_vld_q;
    logic          pix_oor_q;
    logic [CW-1:0] pix_col_q;
    logic          pix_sel_q;

    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [COORD_W-1:0] row_full, col_full;
    logic              oor;
    logic [DATA_W-1:0] b0_rd0, b1_rd0;

    assign vsync_rise = bus.lcd_vsync & ~vsync_q;

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            state_q     <= IDLE;
            front_q     <= 1'b0;
            clr_cnt_q   <= '0;
            swap_pend_q <= 1'b0;
            vsync_q     <= 1'b0;
            pix_vld_q   <= 1'b0;
            pix_oor_q   <= 1'b1;
            pix_col_q   <= '0;
            pix_sel_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            front_q     <= front_d;
            clr_cnt_q   <= clr_cnt_d;
            swap_pend_q <= swap_pend_d;
            vsync_q     <= bus.lcd_vsync;
            pix_vld_q   <= bus.lcd_req;
            if (bus.lcd_req) begin
                pix_oor_q <= oor;
                pix_col_q <= col_full[CW-1:0];
                pix_sel_q <= front_q;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        front_d     = front_q;
        clr_cnt_d   = clr_cnt_q;
        swap_pend_d = swap_pend_q;
        case (state_q)
            IDLE: begin
                if (bus.cpu_clr) begin
                    state_d     = CLEAR;
                    clr_cnt_d   = '0;
                    swap_pend_d = bus.cpu_swap;
                end else if (bus.cpu_swap) begin
                    state_d = SWAP_WAIT;
                end
            end
            CLEAR: begin
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (bus.cpu_swap) swap_pend_d = 1'b1;
                if (clr_cnt_q == AW'(ROWS - 1)) begin
                    state_d     = (swap_pend_q || bus.cpu_swap) ? SWAP_WAIT : IDLE;
                    swap_pend_d = 1'b0;
                end
            end
            SWAP_WAIT: begin
                if (vsync_rise) begin
                    front_d = ~front_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.cpu_wr_ready = (state_q == IDLE);
    assign bus.cpu_busy     = (state_q != IDLE);

    // The back bank is !front: bank0 takes writes while bank1 is on screen and vice versa.
    assign wr_en   = (state_q == CLEAR) || ((state_q == IDLE) && bus.cpu_wr_valid);
    assign wr_addr = (state_q == CLEAR) ? clr_cnt_q : bus.cpu_wr_addr;
    assign wr_data = (state_q == CLEAR) ? '0 : bus.cpu_wr_data;

    assign row_full = bus.lcd_y >> SCALE_SH;
    assign col_full = bus.lcd_x >> SCALE_SH;
    assign oor      = (row_full >= COORD_W'(ROWS)) || (col_full >= COORD_W'(DATA_W));

    assign bus.lcd_pix_vld = pix_vld_q;
    assign bus.lcd_pix     = pix_oor_q ? BG_RGB
                           : bit_to_rgb(pix_sel_q ? b1_rd0[pix_col_q] : b0_rd0[pix_col_q],
                                        FG_RGB, BG_RGB);

`ifdef VMEM_FB_READBACK_EN
    logic              rb_sel_q;
    logic [DATA_W-1:0] b0_rd1, b1_rd1;

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst)           rb_sel_q <= 1'b0;
        else if (bus.cpu_rd_en) rb_sel_q <= ~front_q;
    end

    assign bus.cpu_rd_data = rb_sel_q ? b1_rd1 : b0_rd1;
`endif

    vmem_fb_bank #(.DATA_W(DATA_W), .ROWS(ROWS)) u_bank0 (
        .clk        (sys_clk),
        .rst_n      (sys_rst),
        .we_i       (wr_en & front_q),
        .waddr_i    (wr_addr),
        .wdata_i    (wr_data),
        .rd0_en_i   (bus.lcd_req),
        .rd0_addr_i (row_full[AW-1:0]),
        .rd0_data_o (b0_rd0)
`ifdef VMEM_FB_READBACK_EN
        ,
        .rd1_en_i   (bus.cpu_rd_en),
        .rd1_addr_i (bus.cpu_rd_addr),
        .rd1_data_o (b0_rd1)
`endif
    );

    vmem_fb_bank #(.DATA_W(DATA_W), .ROWS(ROWS)) u_bank1 (
        .clk        (sys_clk),
        .rst_n      (sys_rst),
        .we_i       (wr_en & ~front_q),
        .waddr_i    (wr_addr),
        .wdata_i    (wr_data),
        .rd0_en_i   (bus.lcd_req),
        .rd0_addr_i (row_full[AW-1:0]),
        .rd0_data_o (b1_rd0)
`ifdef VMEM_FB_READBACK_EN
        ,
        .rd1_en_i   (bus.cpu_rd_en),
        .rd1_addr_i (bus.cpu_rd_addr),
        .rd1_data_o (b1_rd1)
`endif
    );

endmodule
